pwm_capture: RTL

Measures an incoming PWM waveform (period and high time, in `clk` cycles) on a single asynchronous input pin. It is the receive-side counterpart of the status-LED PWM generators: an external agent (ESP32 LEDC/RMT output, or a loopback of an FPGA PWM pin) drives `pwm_in`, and this block reports each completed cycle with a one-cycle `valid` strobe. It sits between an input pad and the register/debug logic that consumes the measurements.

---
 rtl/pwm_capture_pkg.sv | 22 ++
 rtl/sync_edge_detect.sv | 45 ++++
 rtl/pwm_capture.sv | 137 +++++++++++++
 3 files changed

// File: rtl/pwm_capture_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pwm_capture_pkg
// Description : Shared types for the PWM capture block: the measurement
//               state machine encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package pwm_capture_pkg;

    // IDLE : block disabled, counter held at zero
    // ARM  : waiting for the first rising edge of a new measurement
    // HIGH : input is high, waiting for the falling edge
    // LOW  : input is low, waiting for the rising edge that closes the period
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARM  = 2'd1,
        HIGH = 2'd2,
        LOW  = 2'd3
    } state_t;

endpackage : pwm_capture_pkg
`default_nettype wire

// File: rtl/sync_edge_detect.sv
`default_nettype none
// ============================================================================
// Module      : sync_edge_detect
// Description : Two-flop synchronizer followed by a delay flop for an
//               asynchronous pad input. Produces the synchronized level and
//               single-cycle rise/fall pulses in the clk domain.
// Ports       : clk      - system clock
//               rst      - asynchronous active-high reset
//               i_async  - asynchronous input pin
//               o_level  - synchronized level
//               o_rise   - one-cycle pulse on a synchronized 0->1 transition
//               o_fall   - one-cycle pulse on a synchronized 1->0 transition
// Revision    : 1.0 - initial release
// ============================================================================
module sync_edge_detect (
    input  logic clk,
    input  logic rst,
    input  logic i_async,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);

    logic r_s1;
    logic r_s2;
    logic r_s3;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
            r_s3 <= 1'b0;
        end else begin
            r_s1 <= i_async;
            r_s2 <= r_s1;
            r_s3 <= r_s2;
        end
    end

    assign o_level = r_s2;
    assign o_rise  = r_s2 & ~r_s3;
    assign o_fall  = ~r_s2 & r_s3;

endmodule : sync_edge_detect
`default_nettype wire

// File: rtl/pwm_capture.sv
`default_nettype none
// ============================================================================
// Module      : pwm_capture
// Description : Measures period and high time (in clk cycles) of an
//               asynchronous PWM input. Each completed period is reported
//               with a one-cycle valid strobe; a missing edge for
//               2^CNT_WIDTH-1 cycles raises a one-cycle timeout strobe and
//               records the stuck input level.
// Ports       : clk         - system clock
//               rst         - asynchronous active-high reset
//               enable      - synchronous enable, low forces IDLE
//               pwm_in      - asynchronous PWM input
//               period      - cycles between the last two rising edges
//               high_time   - cycles from rise to fall in that period
//               valid       - period/high_time updated this cycle
//               timeout     - no edge seen for 2^CNT_WIDTH-1 cycles
//               stuck_level - synchronized input level at last timeout
// Revision    : 1.0 - initial release
// ============================================================================
module pwm_capture
    import pwm_capture_pkg::*;
#(
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable,
    input  logic                 pwm_in,
    output logic [CNT_WIDTH-1:0] period,
    output logic [CNT_WIDTH-1:0] high_time,
    output logic                 valid,
    output logic                 timeout,
    output logic                 stuck_level
);

    localparam logic [CNT_WIDTH-1:0] C_CNT_MAX = {CNT_WIDTH{1'b1}};
    localparam logic [CNT_WIDTH-1:0] C_CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    logic                 w_level;
    logic                 w_rise;
    logic                 w_fall;
    logic                 w_edge;

    state_t               r_state;
    logic [CNT_WIDTH-1:0] r_cnt;
    logic [CNT_WIDTH-1:0] r_hi_tmp;
    logic [CNT_WIDTH-1:0] r_period;
    logic [CNT_WIDTH-1:0] r_high_time;
    logic                 r_valid;
    logic                 r_timeout;
    logic                 r_stuck_level;

    sync_edge_detect u_sync (
        .clk     (clk),
        .rst     (rst),
        .i_async (pwm_in),
        .o_level (w_level),
        .o_rise  (w_rise),
        .o_fall  (w_fall)
    );

    assign w_edge = w_rise | w_fall;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= IDLE;
            r_cnt         <= '0;
            r_hi_tmp      <= '0;
            r_period      <= '0;
            r_high_time   <= '0;
            r_valid       <= 1'b0;
            r_timeout     <= 1'b0;
            r_stuck_level <= 1'b0;
        end else begin
            r_valid   <= 1'b0;
            r_timeout <= 1'b0;

            if (!enable) begin
                r_state <= IDLE;
                r_cnt   <= '0;
            end else begin
                // A rise restarts the count at 1 so the value seen on the next
                // edge equals the number of cycles since this one.
                if (r_state == IDLE) begin
                    r_cnt <= '0;
                end else if (w_rise) begin
                    r_cnt <= C_CNT_ONE;
                end else if (r_cnt != C_CNT_MAX) begin
                    r_cnt <= r_cnt + C_CNT_ONE;
                end

                case (r_state)
                    IDLE: r_state <= ARM;
                    ARM: begin
                        if (w_rise) begin
                            r_state <= HIGH;
                        end
                    end
                    HIGH: begin
                        if (w_fall) begin
                            r_hi_tmp <= r_cnt;
                            r_state  <= LOW;
                        end
                    end
                    LOW: begin
                        if (w_rise) begin
                            r_period    <= r_cnt;
                            r_high_time <= r_hi_tmp;
                            r_valid     <= 1'b1;
                            r_state     <= HIGH;
                        end
                    end
                    default: r_state <= IDLE;
                endcase

                // Saturated with no edge: give up on this measurement. An edge
                // in the saturation cycle takes precedence. The counter restarts
                // so a line that stays stuck produces one strobe per full count
                // rather than one every cycle.
                if (r_state != IDLE && r_cnt == C_CNT_MAX && !w_edge) begin
                    r_timeout     <= 1'b1;
                    r_stuck_level <= w_level;
                    r_state       <= ARM;
                    r_cnt         <= '0;
                end
            end
        end
    end

    assign period      = r_period;
    assign high_time   = r_high_time;
    assign valid       = r_valid;
    assign timeout     = r_timeout;
    assign stuck_level = r_stuck_level;

endmodule : pwm_capture
`default_nettype wire
